// File: rtl/croc_jtag_tap_sampled.sv
// croc_jtag_tap_sampled: IEEE 1149.1 TAP responder running entirely on clk_i.
// JTAG pins are oversampled; TCK edges are detected in logic, never used as a clock.
module croc_jtag_tap_sampled #(
   parameter logic [31:0]         IdcodeValue = 32'h0000_0DB3,
   parameter int unsigned         IrLength    = 5,
   parameter logic [IrLength-1:0] UserIr      = 5'h10,
   parameter int unsigned         SyncStages  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        jtag_tck_i,
   input  logic        jtag_tms_i,
   input  logic        jtag_tdi_i,
   input  logic        jtag_trst_ni,
   output logic        jtag_tdo_o,
   output logic        jtag_tdo_oe_o,
   input  logic [31:0] user_rdata_i,
   output logic [31:0] user_wdata_o,
   output logic        user_wvalid_o
);

   localparam logic [3:0] StExit2Dr   = 4'h0;
   localparam logic [3:0] StExit1Dr   = 4'h1;
   localparam logic [3:0] StShiftDr   = 4'h2;
   localparam logic [3:0] StPauseDr   = 4'h3;
   localparam logic [3:0] StSelIr     = 4'h4;
   localparam logic [3:0] StUpdateDr  = 4'h5;
   localparam logic [3:0] StCaptureDr = 4'h6;
   localparam logic [3:0] StSelDr     = 4'h7;
   localparam logic [3:0] StExit2Ir   = 4'h8;
   localparam logic [3:0] StExit1Ir   = 4'h9;
   localparam logic [3:0] StShiftIr   = 4'hA;
   localparam logic [3:0] StPauseIr   = 4'hB;
   localparam logic [3:0] StIdle      = 4'hC;
   localparam logic [3:0] StUpdateIr  = 4'hD;
   localparam logic [3:0] StCaptureIr = 4'hE;
   localparam logic [3:0] StReset     = 4'hF;

   localparam logic [IrLength-1:0] IrIdcode  = IrLength'(1);
   localparam logic [IrLength-1:0] IrCapture = IrLength'(1);

   logic [SyncStages-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
   logic                  tck_d;
   logic                  tck_s, tms_s, tdi_s, trst_s;
   logic                  tck_rise, tck_fall;

   logic [3:0]            state, state_next;
   logic [IrLength-1:0]   ir, ir_shreg;
   logic [31:0]           dr_shreg;
   logic                  bypass_shreg;
   logic                  sel_idcode, sel_user;

   assign tck_s  = tck_sync[SyncStages-1];
   assign tms_s  = tms_sync[SyncStages-1];
   assign tdi_s  = tdi_sync[SyncStages-1];
   assign trst_s = trst_sync[SyncStages-1];

   // tck_s and tck_d differ in at most one direction per cycle, so rise/fall are one-hot
   assign tck_rise = tck_s & ~tck_d;
   assign tck_fall = ~tck_s & tck_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tck_sync  <= '0;
         tms_sync  <= '1;
         tdi_sync  <= '0;
         trst_sync <= '0;
         tck_d     <= 1'b0;
      end else begin
         tck_sync  <= {tck_sync[SyncStages-2:0], jtag_tck_i};
         tms_sync  <= {tms_sync[SyncStages-2:0], jtag_tms_i};
         tdi_sync  <= {tdi_sync[SyncStages-2:0], jtag_tdi_i};
         trst_sync <= {trst_sync[SyncStages-2:0], jtag_trst_ni};
         tck_d     <= tck_s;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         StReset:     state_next = tms_s ? StReset    : StIdle;
         StIdle:      state_next = tms_s ? StSelDr    : StIdle;
         StSelDr:     state_next = tms_s ? StSelIr    : StCaptureDr;
         StCaptureDr: state_next = tms_s ? StExit1Dr  : StShiftDr;
         StShiftDr:   state_next = tms_s ? StExit1Dr  : StShiftDr;
         StExit1Dr:   state_next = tms_s ? StUpdateDr : StPauseDr;
         StPauseDr:   state_next = tms_s ? StExit2Dr  : StPauseDr;
         StExit2Dr:   state_next = tms_s ? StUpdateDr : StShiftDr;
         StUpdateDr:  state_next = tms_s ? StSelDr    : StIdle;
         StSelIr:     state_next = tms_s ? StReset    : StCaptureIr;
         StCaptureIr: state_next = tms_s ? StExit1Ir  : StShiftIr;
         StShiftIr:   state_next = tms_s ? StExit1Ir  : StShiftIr;
         StExit1Ir:   state_next = tms_s ? StUpdateIr : StPauseIr;
         StPauseIr:   state_next = tms_s ? StExit2Ir  : StPauseIr;
         StExit2Ir:   state_next = tms_s ? StUpdateIr : StShiftIr;
         StUpdateIr:  state_next = tms_s ? StSelDr    : StIdle;
         default:     state_next = StReset;
      endcase
   end

   // Anything not IDCODE or USER (including all-ones) selects the 1-bit BYPASS register
   assign sel_idcode = (ir == IrIdcode);
   assign sel_user   = (ir == UserIr) && !sel_idcode;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state         <= StReset;
         ir            <= IrIdcode;
         ir_shreg      <= '0;
         dr_shreg      <= '0;
         bypass_shreg  <= 1'b0;
         jtag_tdo_o    <= 1'b0;
         jtag_tdo_oe_o <= 1'b0;
         user_wdata_o  <= '0;
         user_wvalid_o <= 1'b0;
      end else begin
         user_wvalid_o <= 1'b0;
         if (!trst_s) begin
            state         <= StReset;
            ir            <= IrIdcode;
            jtag_tdo_oe_o <= 1'b0;
         end else begin
            // Capture/shift act on the rise that leaves the state, as in a real TAP
            if (tck_rise) begin
               case (state)
                  StCaptureIr: ir_shreg <= IrCapture;
                  StShiftIr:   ir_shreg <= {tdi_s, ir_shreg[IrLength-1:1]};
                  StCaptureDr: begin
                     if (sel_idcode)    dr_shreg     <= IdcodeValue;
                     else if (sel_user) dr_shreg     <= user_rdata_i;
                     else               bypass_shreg <= 1'b0;
                  end
                  StShiftDr: begin
                     if (sel_idcode || sel_user) dr_shreg <= {tdi_s, dr_shreg[31:1]};
                     else                        bypass_shreg <= tdi_s;
                  end
                  default: ;
               endcase
               state <= state_next;
            end
            if (tck_fall) begin
               case (state)
                  StShiftIr: begin
                     jtag_tdo_o    <= ir_shreg[0];
                     jtag_tdo_oe_o <= 1'b1;
                  end
                  StShiftDr: begin
                     jtag_tdo_o    <= (sel_idcode || sel_user) ? dr_shreg[0] : bypass_shreg;
                     jtag_tdo_oe_o <= 1'b1;
                  end
                  StUpdateIr: begin
                     ir            <= ir_shreg;
                     jtag_tdo_oe_o <= 1'b0;
                  end
                  StUpdateDr: begin
                     if (sel_user) begin
                        user_wdata_o  <= dr_shreg;
                        user_wvalid_o <= 1'b1;
                     end
                     jtag_tdo_oe_o <= 1'b0;
                  end
                  default: jtag_tdo_oe_o <= 1'b0;
               endcase
            end
            if (state == StReset) ir <= IrIdcode;
         end
      end
   end

endmodule

// File: tb/tb_croc_jtag_tap_sampled.sv
// Self-checking bench for croc_jtag_tap_sampled: directed scans against fixed
// values plus a random TMS/TDI walk against a behavioural TAP model.
module tb_croc_jtag_tap_sampled;

   localparam int HALF = 4;  // SyncStages+2 clk_i cycles per TCK phase

   // Standard IEEE 1149.1 TAP state codes
   localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SHDR = 4'h2, S_SHIR = 4'hA;
   localparam logic [3:0] S_CAPDR = 4'h6, S_CAPIR = 4'hE, S_UPDDR = 4'h5, S_UPDIR = 4'hD;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        jtag_tck = 1'b0, jtag_tms = 1'b1, jtag_tdi = 1'b0, jtag_trst_n = 1'b1;
   logic        jtag_tdo_o, jtag_tdo_oe_o;
   logic [31:0] user_rdata = '0;
   logic [31:0] user_wdata_o;
   logic        user_wvalid_o;

   int n_cmp = 0;
   int n_err = 0;
   int wv_pulses = 0;
   int wv_long = 0;
   logic wv_prev = 1'b0;

   // Next-state tables indexed by state code: [tms=0], [tms=1]
   logic [3:0] nx0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
   logic [3:0] nx1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

   logic [3:0]  m_state;
   logic [4:0]  m_ir, m_irsr;
   logic [31:0] m_dr, m_wdata;
   logic        m_bp, m_tdo, m_oe;
   int          m_wv;

   croc_jtag_tap_sampled #(
      .IdcodeValue(32'h0000_0DB3),
      .IrLength   (5),
      .UserIr     (5'h10),
      .SyncStages (2)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .jtag_tck_i   (jtag_tck),
      .jtag_tms_i   (jtag_tms),
      .jtag_tdi_i   (jtag_tdi),
      .jtag_trst_ni (jtag_trst_n),
      .jtag_tdo_o   (jtag_tdo_o),
      .jtag_tdo_oe_o(jtag_tdo_oe_o),
      .user_rdata_i (user_rdata),
      .user_wdata_o (user_wdata_o),
      .user_wvalid_o(user_wvalid_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (user_wvalid_o === 1'b1) begin
         wv_pulses++;
         if (wv_prev) wv_long++;
      end
      wv_prev = user_wvalid_o;
   end

   task automatic model_reset_all();
      m_state = S_TLR; m_ir = 5'h01; m_irsr = '0; m_dr = '0; m_wdata = '0;
      m_bp = 1'b0; m_tdo = 1'b0; m_oe = 1'b0;
   endtask

   task automatic model_rise(input logic tms, input logic tdi);
      case (m_state)
         S_CAPIR: m_irsr = 5'b00001;
         S_SHIR:  m_irsr = {tdi, m_irsr[4:1]};
         S_CAPDR: if (m_ir == 5'h01) m_dr = 32'h0000_0DB3;
                  else if (m_ir == 5'h10) m_dr = user_rdata;
                  else m_bp = 1'b0;
         S_SHDR:  if (m_ir == 5'h01 || m_ir == 5'h10) m_dr = {tdi, m_dr[31:1]};
                  else m_bp = tdi;
         default: ;
      endcase
      m_state = tms ? nx1[m_state] : nx0[m_state];
      if (m_state == S_TLR) m_ir = 5'h01;
   endtask

   task automatic model_fall();
      m_oe = 1'b0;
      if (m_state == S_SHIR) begin m_tdo = m_irsr[0]; m_oe = 1'b1; end
      if (m_state == S_SHDR) begin
         m_tdo = (m_ir == 5'h01 || m_ir == 5'h10) ? m_dr[0] : m_bp;
         m_oe = 1'b1;
      end
      if (m_state == S_UPDIR) m_ir = m_irsr;
      if (m_state == S_UPDDR && m_ir == 5'h10) begin m_wdata = m_dr; m_wv++; end
   endtask

   // One full TCK period; returns TDO/OE after the fall and the DUT state after the rise
   task automatic do_tck(input logic tms, input logic tdi,
                         output logic tdo, output logic oe, output logic [3:0] st);
      jtag_tms = tms;
      jtag_tdi = tdi;
      model_rise(tms, tdi);
      @(negedge clk_i);
      jtag_tck = 1'b1;
      repeat (HALF) @(negedge clk_i);
      st = dut.state;
      jtag_tck = 1'b0;
      model_fall();
      repeat (HALF) @(negedge clk_i);
      tdo = jtag_tdo_o;
      oe  = jtag_tdo_oe_o;
   endtask

   task automatic tck1(input logic tms, input logic tdi);
      logic t, o;
      logic [3:0] s;
      do_tck(tms, tdi, t, o, s);
   endtask

   task automatic goto_rti();
      for (int i = 0; i < 5; i++) tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
   endtask

   // From RTI: scan n DR bits, finish in RTI through Update-DR
   task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout,
                          output logic oe_in, output logic oe_out);
      logic t, o;
      logic [3:0] s;
      dout = '0;
      tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
      do_tck(1'b0, 1'b0, t, o, s);
      dout[0] = t;
      oe_in = o;
      oe_out = 1'b0;
      for (int i = 0; i < n; i++) begin
         do_tck(i == n - 1, din[i], t, o, s);
         if (i < n - 1) begin dout[i+1] = t; oe_in &= o; end
         else oe_out = o;
      end
      tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
   endtask

   task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
      logic t, o;
      logic [3:0] s;
      dout = '0;
      tck1(1'b1, 1'b0);
      tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
      do_tck(1'b0, 1'b0, t, o, s);
      dout[0] = t;
      for (int i = 0; i < 5; i++) begin
         do_tck(i == 4, din[i], t, o, s);
         if (i < 4) dout[i+1] = t;
      end
      tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      model_reset_all();
      repeat (4) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (6) @(negedge clk_i);
      n_cmp++; if (dut.state !== S_TLR) begin n_err++; $display("FAIL reset_state: got %h expected %h", dut.state, S_TLR); end
      n_cmp++; if (dut.ir !== 5'h01) begin n_err++; $display("FAIL reset_ir: got %h expected 01", dut.ir); end
      n_cmp++; if ({jtag_tdo_o, jtag_tdo_oe_o, user_wvalid_o} !== 3'b000) begin n_err++; $display("FAIL reset_outs: tdo/oe/wvalid got %b expected 000", {jtag_tdo_o, jtag_tdo_oe_o, user_wvalid_o}); end
      n_cmp++; if (user_wdata_o !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h expected 0", user_wdata_o); end
   endtask

   task automatic test_idcode();
      logic [31:0] d;
      logic oi, oo;
      goto_rti();
      scan_dr(32, 32'h0, d, oi, oo);
      n_cmp++; if (d !== 32'h0000_0DB3) begin n_err++; $display("FAIL idcode_tdo: got %h expected 00000db3", d); end
      n_cmp++; if (oi !== 1'b1) begin n_err++; $display("FAIL idcode_oe_shift: got %b expected 1", oi); end
      n_cmp++; if (oo !== 1'b0) begin n_err++; $display("FAIL idcode_oe_exit: got %b expected 0", oo); end
   endtask

   task automatic test_ir_bypass();
      logic [4:0] ir_out;
      logic [31:0] d;
      logic oi, oo;
      scan_ir(5'h00, ir_out);
      n_cmp++; if (ir_out !== 5'b00001) begin n_err++; $display("FAIL ir_capture: got %b expected 00001", ir_out); end
      scan_ir(5'h1F, ir_out);
      n_cmp++; if (dut.ir !== 5'h1F) begin n_err++; $display("FAIL ir_update: got %h expected 1f", dut.ir); end
      scan_dr(4, 32'hD, d, oi, oo);
      n_cmp++; if (d[3:0] !== 4'b1010) begin n_err++; $display("FAIL bypass_tdo: got %b expected 1010", d[3:0]); end
   endtask

   task automatic test_user();
      logic [4:0] ir_out;
      logic [31:0] d;
      logic oi, oo;
      int p0;
      scan_ir(5'h10, ir_out);
      user_rdata = 32'hCAFE_BABE;
      p0 = wv_pulses;
      scan_dr(32, 32'h1234_5678, d, oi, oo);
      repeat (4) @(negedge clk_i);
      n_cmp++; if (d !== 32'hCAFE_BABE) begin n_err++; $display("FAIL user_tdo: got %h expected cafebabe", d); end
      n_cmp++; if (user_wdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL user_wdata: got %h expected 12345678", user_wdata_o); end
      n_cmp++; if (wv_pulses - p0 !== 1) begin n_err++; $display("FAIL user_wvalid_count: got %0d expected 1", wv_pulses - p0); end
      n_cmp++; if (wv_long !== 0) begin n_err++; $display("FAIL user_wvalid_width: got %0d long pulses expected 0", wv_long); end
   endtask

   task automatic test_pause_resume();
      logic t, o;
      logic [3:0] s;
      logic [31:0] din, d;
      int p0;
      din = 32'h8765_4321;
      user_rdata = 32'h0BAD_F00D;
      p0 = wv_pulses;
      d = '0;
      tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
      do_tck(1'b0, 1'b0, t, o, s);
      d[0] = t;
      for (int i = 0; i < 16; i++) begin
         do_tck(i == 15, din[i], t, o, s);
         if (i < 15) d[i+1] = t;
      end
      tck1(1'b0, 1'b0);
      tck1(1'b0, 1'b0);
      do_tck(1'b1, 1'b0, t, o, s);
      n_cmp++; if (o !== 1'b0) begin n_err++; $display("FAIL pause_oe: got %b expected 0", o); end
      do_tck(1'b0, 1'b0, t, o, s);
      d[16] = t;
      for (int i = 16; i < 32; i++) begin
         do_tck(i == 31, din[i], t, o, s);
         if (i < 31) d[i+1] = t;
      end
      tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
      repeat (4) @(negedge clk_i);
      n_cmp++; if (d !== 32'h0BAD_F00D) begin n_err++; $display("FAIL pause_tdo: got %h expected 0badf00d", d); end
      n_cmp++; if (user_wdata_o !== din) begin n_err++; $display("FAIL pause_wdata: got %h expected %h", user_wdata_o, din); end
      n_cmp++; if (wv_pulses - p0 !== 1) begin n_err++; $display("FAIL pause_wvalid_count: got %0d expected 1", wv_pulses - p0); end
   endtask

   task automatic test_trst_mid_scan();
      logic [31:0] d, w0;
      logic oi, oo;
      int p0;
      w0 = user_wdata_o;
      p0 = wv_pulses;
      tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
      tck1(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tck1(1'b0, 1'b1);
      jtag_trst_n = 1'b0;
      m_state = S_TLR; m_ir = 5'h01; m_oe = 1'b0;
      repeat (8) @(negedge clk_i);
      n_cmp++; if (dut.state !== S_TLR) begin n_err++; $display("FAIL trst_state: got %h expected %h", dut.state, S_TLR); end
      n_cmp++; if (dut.ir !== 5'h01) begin n_err++; $display("FAIL trst_ir: got %h expected 01", dut.ir); end
      jtag_trst_n = 1'b1;
      repeat (4) @(negedge clk_i);
      tck1(1'b0, 1'b0);
      scan_dr(32, 32'hFFFF_FFFF, d, oi, oo);
      repeat (4) @(negedge clk_i);
      n_cmp++; if (d !== 32'h0000_0DB3) begin n_err++; $display("FAIL trst_idcode: got %h expected 00000db3", d); end
      n_cmp++; if (wv_pulses !== p0) begin n_err++; $display("FAIL trst_wvalid: got %0d pulses expected %0d", wv_pulses, p0); end
      n_cmp++; if (user_wdata_o !== w0) begin n_err++; $display("FAIL trst_wdata: got %h expected %h", user_wdata_o, w0); end
   endtask

   task automatic test_rst_mid_scan();
      logic [4:0] ir_out;
      logic [3:0] s;
      logic t, o;
      int p0;
      scan_ir(5'h10, ir_out);
      p0 = wv_pulses;
      tck1(1'b1, 1'b0);
      tck1(1'b0, 1'b0);
      tck1(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) tck1(1'b0, 1'b1);
      rst_ni = 1'b0;
      model_reset_all();
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (6) @(negedge clk_i);
      n_cmp++; if (user_wdata_o !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h expected 0", user_wdata_o); end
      n_cmp++; if (dut.state !== S_TLR) begin n_err++; $display("FAIL rst_state: got %h expected %h", dut.state, S_TLR); end
      do_tck(1'b0, 1'b0, t, o, s);
      n_cmp++; if (s !== S_RTI) begin n_err++; $display("FAIL rst_next_rti: got %h expected %h", s, S_RTI); end
      n_cmp++; if (wv_pulses !== p0) begin n_err++; $display("FAIL rst_wvalid: got %0d pulses expected %0d", wv_pulses, p0); end
   endtask

   task automatic test_random_walk();
      logic t, o, tms, tdi;
      logic [3:0] s;
      int p0, w0;
      logic [4:0] ir_out;
      scan_ir(5'h10, ir_out);
      p0 = wv_pulses;
      w0 = m_wv;
      for (int i = 0; i < 300; i++) begin
         tms = ($urandom_range(0, 99) < 35);
         tdi = $urandom_range(0, 1) != 0;
         user_rdata = $urandom;
         do_tck(tms, tdi, t, o, s);
         n_cmp++; if (s !== m_state) begin n_err++; $display("FAIL walk_state[%0d]: got %h expected %h", i, s, m_state); end
         n_cmp++; if (dut.ir !== m_ir) begin n_err++; $display("FAIL walk_ir[%0d]: got %h expected %h", i, dut.ir, m_ir); end
         n_cmp++; if (o !== m_oe) begin n_err++; $display("FAIL walk_oe[%0d]: got %b expected %b", i, o, m_oe); end
         n_cmp++; if (t !== m_tdo) begin n_err++; $display("FAIL walk_tdo[%0d]: got %b expected %b", i, t, m_tdo); end
         n_cmp++; if (user_wdata_o !== m_wdata) begin n_err++; $display("FAIL walk_wdata[%0d]: got %h expected %h", i, user_wdata_o, m_wdata); end
      end
      repeat (4) @(negedge clk_i);
      n_cmp++; if (wv_pulses - p0 !== m_wv - w0) begin n_err++; $display("FAIL walk_wvalid_count: got %0d expected %0d", wv_pulses - p0, m_wv - w0); end
      n_cmp++; if (wv_long !== 0) begin n_err++; $display("FAIL walk_wvalid_width: got %0d long pulses expected 0", wv_long); end
   endtask

   initial begin
      m_wv = 0;
      model_reset_all();
      test_reset();
      test_idcode();
      test_ir_bypass();
      test_user();
      test_pause_resume();
      test_trst_mid_scan();
      test_rst_mid_scan();
      test_random_walk();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
